// File: rtl/prng_pkg.sv
// Shared types and helper functions for the multi-lane LFSR random source.
// Tap masks, seed-spreading constants and per-lane seed derivation.
package prng_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } prng_state_e;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            16:      return 32'h0000_002D;
            24:      return 32'h0000_0087;
            default: return 32'hC000_0401;
        endcase
    endfunction

    function automatic logic [31:0] golden(input int width);
        case (width)
            16:      return 32'h0000_9E37;
            24:      return 32'h009E_3779;
            default: return 32'h9E37_79B9;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    endfunction

    // All-zero is the lock-up state of an XOR LFSR, so it is replaced by all-ones.
    function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int c, input int width);
        logic [31:0] mask;
        logic [31:0] s;
        mask = width_mask(width);
        s    = (seed ^ (32'(c) * golden(width))) & mask;
        if (s == 32'h0) s = mask;
        return s;
    endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One Fibonacci LFSR lane: state register plus a STEPS-deep unrolled shifter.
// Load has priority over advance.
module lfsr_lane #(
    parameter int               WIDTH   = 16,
    parameter int               STEPS   = 1,
    parameter logic [WIDTH-1:0] TAPS    = '0,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             adv,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] nxt;

    // NOTE: blocking '=' here is intentional; each loop iteration feeds the next within one evaluation.
    always_comb begin
        nxt = state_q;
        for (int i = 0; i < STEPS; i++) begin
            nxt = {^(nxt & TAPS), nxt[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       state_q <= RST_VAL;
        else if (load) state_q <= load_val;
        else if (adv)  state_q <= nxt;
    end

    assign state = state_q;

endmodule

// File: rtl/prng_multi.sv
// Multi-lane LFSR random source with warm-up, runtime reseed and a
// valid/ready stream delivering all lanes in one beat.
module prng_multi
    import prng_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          NUM_CH       = 4,
    parameter int          STEPS        = 1,
    parameter int          WARMUP_DRAWS = 0,
    parameter logic [31:0] SEED         = 32'hbeef
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reseed_valid,
    output logic                    reseed_ready,
    input  logic [WIDTH-1:0]        reseed_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [31:0]             draw_count
);

    if (!(WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
        $error("prng_multi: WIDTH must be 16, 24 or 32");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("prng_multi: NUM_CH must be 1..16");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("prng_multi: STEPS must be 1..WIDTH");
    end
    if (WARMUP_DRAWS < 0 || WARMUP_DRAWS > 255) begin : g_bad_warmup
        $error("prng_multi: WARMUP_DRAWS must be 0..255");
    end

    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [7:0]       WARM_INIT = 8'(WARMUP_DRAWS);

    prng_state_e state_q, state_d;
    logic [7:0]  warm_q, warm_d;
    logic        ready_q;
    logic        adv;
    logic        out_fire;
    logic        reseed_fire;
    logic [31:0] seed_ext;

    assign out_valid    = (state_q == RUN);
    assign reseed_ready = ready_q;
    assign out_fire     = out_valid && out_ready;
    assign reseed_fire  = reseed_valid && reseed_ready;
    assign seed_ext     = 32'(reseed_data);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(lane_seed(SEED, c, WIDTH));
        logic [WIDTH-1:0] load_val;

        assign load_val = WIDTH'(lane_seed(seed_ext, c, WIDTH));

        lfsr_lane #(
            .WIDTH   (WIDTH),
            .STEPS   (STEPS),
            .TAPS    (TAPS),
            .RST_VAL (RST_VAL)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (reseed_fire),
            .load_val (load_val),
            .adv      (adv),
            .state    (out_data[c*WIDTH +: WIDTH])
        );
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        adv     = 1'b0;
        if (reseed_fire) begin
            state_d = WARMUP;
            warm_d  = WARM_INIT;
        end else begin
            case (state_q)
                WARMUP: begin
                    if (warm_q != 8'd0) begin
                        adv    = 1'b1;
                        warm_d = warm_q - 8'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN:     adv = out_fire;
                default: state_d = WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WARMUP;
            warm_q     <= WARM_INIT;
            ready_q    <= 1'b0;
            draw_count <= 32'd0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            ready_q <= 1'b1;
            // A reseed coinciding with a fire still consumes the beat, but the count restarts.
            if (reseed_fire)   draw_count <= 32'd0;
            else if (out_fire) draw_count <= draw_count + 32'd1;
        end
    end

endmodule
